// File: rtl/vga_sync_gen.sv
// Pixel-timing generator for the 640x480 @ 60 Hz display path.
// Produces registered syncs, beam coordinates, display enable and line/frame strobes.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CE,
    output logic               HS,
    output logic               VS,
    output logic signed [10:0] x_VGA,
    output logic signed [10:0] y_VGA,
    output logic               de,
    output logic               line_end,
    output logic               frame_end
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_VISIBLE + V_FP + V_SYNC - 1);

    // (0,0) is inside the visible area whenever there is any visible area at all.
    localparam logic DE_RST = 1'((H_VISIBLE > 0) && (V_VISIBLE > 0));

    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic        line_end_q, line_end_d;
    logic        frame_end_q, frame_end_d;
    logic        x_wrap;

    assign x_wrap = (x_q == H_LAST);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (CE) begin
            if (x_wrap) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 11'd1;
            end else begin
                x_d = x_q + 11'd1;
            end
        end
    end

    // Flags decode the next-state counters so they land in the same cycle as the
    // coordinates; with CE=0 the counters hold and so do the flags.
    always_comb begin
        hs_d        = ~SYNC_POL;
        vs_d        = ~SYNC_POL;
        de_d        = 1'b0;
        line_end_d  = 1'b0;
        frame_end_d = 1'b0;
        if ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) begin
            hs_d = SYNC_POL;
        end
        if ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) begin
            vs_d = SYNC_POL;
        end
        de_d        = (x_d < H_VIS) && (y_d < V_VIS);
        line_end_d  = (x_d == H_LAST);
        frame_end_d = line_end_d && (y_d == V_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            x_q         <= '0;
            y_q         <= '0;
            hs_q        <= ~SYNC_POL;
            vs_q        <= ~SYNC_POL;
            de_q        <= DE_RST;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            line_end_q  <= line_end_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign x_VGA     = $signed(x_q);
    assign y_VGA     = $signed(y_q);
    assign HS        = hs_q;
    assign VS        = vs_q;
    assign de        = de_q;
    assign line_end  = line_end_q;
    assign frame_end = frame_end_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing and reduced-timing instances checked against
// a position-count model (expected outputs derived from the number of CE edges since reset).
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b = 1'b1, ce_b = 1'b1;
    logic rst_s = 1'b1, ce_s = 1'b1;
    logic b_hs, b_vs, b_de, b_le, b_fe;
    logic s_hs, s_vs, s_de, s_le, s_fe;
    logic signed [10:0] b_x, b_y, s_x, s_y;

    longint unsigned nb, ns;
    int asserts = 0;
    int fails   = 0;

    vga_sync_gen dut_b (
        .CLK(clk), .RST(rst_b), .CE(ce_b), .HS(b_hs), .VS(b_vs), .x_VGA(b_x), .y_VGA(b_y),
        .de(b_de), .line_end(b_le), .frame_end(b_fe)
    );

    vga_sync_gen #(
        .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_s (
        .CLK(clk), .RST(rst_s), .CE(ce_s), .HS(s_hs), .VS(s_vs), .x_VGA(s_x), .y_VGA(s_y),
        .de(s_de), .line_end(s_le), .frame_end(s_fe)
    );

    // Expected {HS,VS,de,line_end,frame_end,x,y} after n advancing edges since reset.
    function automatic logic [26:0] model(input int unsigned hv, hfp, hsw, hbp,
                                          input int unsigned vv, vfp, vsw, vbp,
                                          input logic pol, input longint unsigned n);
        longint unsigned ht, vt, x, y;
        logic hs, vs, de, le, fe;
        ht = longint'(hv + hfp + hsw + hbp);
        vt = longint'(vv + vfp + vsw + vbp);
        x  = n % ht;
        y  = (n / ht) % vt;
        hs = (x >= hv + hfp && x < hv + hfp + hsw) ? pol : ~pol;
        vs = (y >= vv + vfp && y < vv + vfp + vsw) ? pol : ~pol;
        de = (x < hv) && (y < vv);
        le = (x == ht - 1);
        fe = le && (y == vt - 1);
        return {hs, vs, de, le, fe, 11'(x), 11'(y)};
    endfunction

    function automatic logic [26:0] exp_b(input longint unsigned n);
        return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, n);
    endfunction

    function automatic logic [26:0] exp_s(input longint unsigned n);
        return model(4, 1, 2, 1, 3, 1, 1, 1, 1'b0, n);
    endfunction

    function automatic logic [26:0] obs_b();
        return {b_hs, b_vs, b_de, b_le, b_fe, b_x, b_y};
    endfunction

    function automatic logic [26:0] obs_s();
        return {s_hs, s_vs, s_de, s_le, s_fe, s_x, s_y};
    endfunction

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_b) nb = 0; else if (ce_b) nb++;
        if (rst_s) ns = 0; else if (ce_s) ns++;
    endtask

    task automatic test_reset();
        rst_b = 1'b1; ce_b = 1'b1; rst_s = 1'b1; ce_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            asserts++;
            if (obs_b() !== exp_b(0)) begin
                fails++;
                $display("FAIL reset_b got=%h exp=%h", obs_b(), exp_b(0));
            end
            asserts++;
            if (obs_s() !== exp_s(0)) begin
                fails++;
                $display("FAIL reset_s got=%h exp=%h", obs_s(), exp_s(0));
            end
        end
        rst_b = 1'b0; rst_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            asserts++;
            if (b_x !== 11'(i + 1) || obs_b() !== exp_b(nb)) begin
                fails++;
                $display("FAIL release_count got=%h exp=%h", obs_b(), exp_b(nb));
            end
        end
    endtask

    task automatic test_line_timing();
        int le_cnt = 0, hs_cnt = 0, last_le = -1, period = 0;
        ce_b = 1'b1;
        for (int i = 0; i < 1600; i++) begin
            tick();
            asserts++;
            if (obs_b() !== exp_b(nb)) begin
                fails++;
                $display("FAIL line_timing n=%0d got=%h exp=%h", nb, obs_b(), exp_b(nb));
            end
            if (b_le) begin
                if (last_le >= 0) period = i - last_le;
                last_le = i;
                le_cnt++;
            end
            if (!b_hs) hs_cnt++;
        end
        asserts++;
        if (le_cnt !== 2) begin
            fails++;
            $display("FAIL line_end_count got=%0d exp=2", le_cnt);
        end
        asserts++;
        if (hs_cnt !== 192) begin
            fails++;
            $display("FAIL hs_low_cycles got=%0d exp=192", hs_cnt);
        end
        asserts++;
        if (period !== 800) begin
            fails++;
            $display("FAIL line_period got=%0d exp=800", period);
        end
    endtask

    task automatic test_ce_gating();
        logic       pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int         xs  [4] = '{799, 799, 799, 0};
        logic       les [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        ce_b = 1'b1;
        for (int i = 0; i < 800 && (nb % 800) != 798; i++) tick();
        for (int i = 0; i < 4; i++) begin
            ce_b = pat[i];
            tick();
            asserts++;
            if (b_x !== 11'(xs[i]) || b_le !== les[i] || obs_b() !== exp_b(nb)) begin
                fails++;
                $display("FAIL ce_gating step=%0d x=%0d le=%b exp_x=%0d exp_le=%b",
                         i, b_x, b_le, xs[i], les[i]);
            end
        end
        ce_b = 1'b1;
    endtask

    task automatic test_reset_mid_b();
        ce_b = 1'b1;
        for (int i = 0; i < 800 && (nb % 800) != 700; i++) tick();
        asserts++;
        if (b_x !== 11'sd700 || b_hs !== 1'b0) begin
            fails++;
            $display("FAIL mid_setup_b x=%0d hs=%b exp x=700 hs=0", b_x, b_hs);
        end
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        asserts++;
        if ({b_x, b_y} !== 22'd0 || b_hs !== 1'b1 || b_vs !== 1'b1 || b_de !== 1'b1 ||
            b_le !== 1'b0 || b_fe !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_b got=%h exp=%h", obs_b(), exp_b(0));
        end
    endtask

    task automatic test_small_frames();
        int vs_cnt = 0, hs_cnt = 0, fe_cnt = 0, last_fe = -1;
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        ce_s  = 1'b1;
        for (int i = 0; i < 144; i++) begin
            tick();
            asserts++;
            if (obs_s() !== exp_s(ns)) begin
                fails++;
                $display("FAIL small_frame n=%0d got=%h exp=%h", ns, obs_s(), exp_s(ns));
            end
            if (!s_vs) vs_cnt++;
            if (!s_hs) hs_cnt++;
            if (s_fe) begin
                asserts++;
                if (vs_cnt !== 8 || hs_cnt !== 12) begin
                    fails++;
                    $display("FAIL small_sync_counts vs=%0d hs=%0d exp vs=8 hs=12",
                             vs_cnt, hs_cnt);
                end
                if (last_fe >= 0) begin
                    asserts++;
                    if (i - last_fe !== 48) begin
                        fails++;
                        $display("FAIL small_frame_period got=%0d exp=48", i - last_fe);
                    end
                end
                last_fe = i;
                fe_cnt++;
                vs_cnt = 0;
                hs_cnt = 0;
            end
        end
        asserts++;
        if (fe_cnt !== 3) begin
            fails++;
            $display("FAIL small_frame_end_count got=%0d exp=3", fe_cnt);
        end
    endtask

    task automatic test_reset_mid_s();
        ce_s = 1'b1;
        for (int i = 0; i < 48 && (ns % 48) != 34; i++) tick();
        asserts++;
        if (s_vs !== 1'b0 || s_y !== 11'sd4) begin
            fails++;
            $display("FAIL mid_setup_s y=%0d vs=%b exp y=4 vs=0", s_y, s_vs);
        end
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        asserts++;
        if ({s_x, s_y} !== 22'd0 || s_vs !== 1'b1 || s_hs !== 1'b1 ||
            s_le !== 1'b0 || s_fe !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_s got=%h exp=%h", obs_s(), exp_s(0));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            ce_b  = ($urandom_range(0, 3) != 0);
            ce_s  = ($urandom_range(0, 2) != 0);
            rst_b = ($urandom_range(0, 499) == 0);
            rst_s = ($urandom_range(0, 149) == 0);
            tick();
            asserts++;
            if (obs_b() !== exp_b(nb)) begin
                fails++;
                $display("FAIL random_b n=%0d got=%h exp=%h", nb, obs_b(), exp_b(nb));
            end
            asserts++;
            if (obs_s() !== exp_s(ns)) begin
                fails++;
                $display("FAIL random_s n=%0d got=%h exp=%h", ns, obs_s(), exp_s(ns));
            end
        end
        rst_b = 1'b0; rst_s = 1'b0; ce_b = 1'b1; ce_s = 1'b1;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_ce_gating();
        test_reset_mid_b();
        test_small_frames();
        test_reset_mid_s();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
